// File: rtl/cp0_intc.sv
// cp0_intc -- Coprocessor-0 interrupt/exception controller.
//
// Samples six level-sensitive hardware interrupt lines into Cause.IP, masks
// them with SR.IM/IE/EXL and requests exception entry.  On entry it captures
// EPC, BD and ExcCode and sets EXL.  On eret it clears EXL.  mfc0/mtc0 access
// goes through a register-select port.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous, active-high reset
//   sel        CP0 register number (12 SR, 13 Cause, 14 EPC, 15 PRId)
//   we         mtc0 write strobe
//   wdata      mtc0 write data
//   rdata      mfc0 read data, combinational from sel, 0 for unmapped sel
//   pc         PC of the instruction in MEM
//   bd         instruction in MEM sits in a branch delay slot
//   hwint      level interrupt lines, bit 0 is the timer IRQ
//   exc_valid  synchronous exception present in MEM
//   exc_code   ExcCode of that exception
//   eret       eret executing in MEM
//   intreq     take the exception this cycle (flush and redirect)
//   epc_out    current EPC, the eret target
module cp0_intc #(
  parameter logic [31:0] PRID = 32'h2016_1219
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  sel,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] pc,
  input  logic        bd,
  input  logic [5:0]  hwint,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic        eret,
  output logic        intreq,
  output logic [31:0] epc_out
);

  localparam logic [4:0] SEL_SR    = 5'd12;
  localparam logic [4:0] SEL_CAUSE = 5'd13;
  localparam logic [4:0] SEL_EPC   = 5'd14;
  localparam logic [4:0] SEL_PRID  = 5'd15;

  // SR fields
  logic [5:0]  im;
  logic        exl;
  logic        ie;
  // Cause fields
  logic        cause_bd;
  logic [5:0]  ip;
  logic [4:0]  cause_exc;
  // EPC, low two bits are always zero
  logic [31:0] epc;

  logic        irq_hit;
  logic        exc_hit;
  logic [31:0] entry_pc;

  assign irq_hit  = (|(ip & im)) && ie && !exl;
  assign exc_hit  = exc_valid && !exl;
  // Gated by reset so the pipeline never sees a request while reset is held.
  assign intreq   = !reset && (irq_hit || exc_hit);
  assign entry_pc = bd ? (pc - 32'd4) : pc;
  assign epc_out  = epc;

  always_comb begin
    // NOTE: default first so every path assigns rdata and no latch is inferred.
    rdata = 32'h0;
    unique case (sel)
      SEL_SR:    rdata = {16'h0, im, 8'h0, exl, ie};
      SEL_CAUSE: rdata = {cause_bd, 15'h0, ip, 3'h0, cause_exc, 2'h0};
      SEL_EPC:   rdata = epc;
      SEL_PRID:  rdata = PRID;
      default:   rdata = 32'h0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values; later assignments in the block override earlier ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      im        <= 6'h0;
      exl       <= 1'b0;
      ie        <= 1'b0;
      cause_bd  <= 1'b0;
      ip        <= 6'h0;
      cause_exc <= 5'h0;
      epc       <= 32'h0;
    end else begin
      // IP mirrors the lines with no latching; a released line clears its bit.
      ip <= hwint;
      if (intreq) begin
        // Entry beats any simultaneous mtc0 or eret; interrupts beat exceptions.
        epc       <= {entry_pc[31:2], 2'b00};
        cause_bd  <= bd;
        cause_exc <= irq_hit ? 5'd0 : exc_code;
        exl       <= 1'b1;
      end else begin
        if (we) begin
          case (sel)
            SEL_SR: begin
              im  <= wdata[15:10];
              exl <= wdata[1];
              ie  <= wdata[0];
            end
            SEL_EPC: epc <= {wdata[31:2], 2'b00};
            default: ;
          endcase
        end
        // Placed after the write so an eret alongside an SR write clears EXL.
        if (eret) exl <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cp0_intc.sv
// tb_cp0_intc -- self-checking bench for cp0_intc.
//
// Directed steps follow the documented behaviour, then randomized traffic is
// compared cycle by cycle against a register-word reference model.
module tb_cp0_intc;

  localparam logic [31:0] PRID_VAL = 32'h2016_1219;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  sel;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] pc;
  logic        bd;
  logic [5:0]  hwint;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic        eret;
  logic        intreq;
  logic [31:0] epc_out;

  int total = 0;
  int bad   = 0;

  // Reference model: architectural register words.
  logic [31:0] m_sr, m_cause, m_epc;

  cp0_intc dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .we        (we),
    .wdata     (wdata),
    .rdata     (rdata),
    .pc        (pc),
    .bd        (bd),
    .hwint     (hwint),
    .exc_valid (exc_valid),
    .exc_code  (exc_code),
    .eret      (eret),
    .intreq    (intreq),
    .epc_out   (epc_out)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_irq();
    return ((m_cause[15:10] & m_sr[15:10]) != 6'h0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_intreq();
    return !reset && (m_irq() || (exc_valid && !m_sr[1]));
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] s);
    case (s)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID_VAL;
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs held across it.
  task automatic model_step();
    logic        take;
    logic        irq;
    logic [31:0] ret_pc;
    take = m_intreq();
    irq  = m_irq();
    if (reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else begin
      if (take) begin
        ret_pc  = bd ? pc - 4 : pc;
        m_epc   = ret_pc & 32'hFFFF_FFFC;
        m_cause = (bd ? 32'h8000_0000 : 0) | (irq ? 0 : 32'(exc_code) * 4);
        m_sr    = m_sr | 32'h2;
      end else begin
        if (we && sel == 5'd12) m_sr  = wdata & 32'h0000_FC03;
        if (we && sel == 5'd14) m_epc = wdata & 32'hFFFF_FFFC;
        if (eret) m_sr = m_sr & ~32'h2;
      end
      m_cause = (m_cause & 32'h8000_007C) | (32'(hwint) * 1024);
    end
  endtask

  // Called at a falling edge with inputs already applied.
  task automatic tick();
    #1;
    check("intreq", 32'(intreq), 32'(m_intreq()));
    check("rdata", rdata, m_read(sel));
    check("epc_out", epc_out, m_epc);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic read(input string tag, input logic [4:0] s, input logic [31:0] exp);
    sel = s;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic mtc0(input logic [4:0] s, input logic [31:0] d);
    sel = s; we = 1'b1; wdata = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sel = 5'd0; we = 1'b0; wdata = 0; pc = 0; bd = 1'b0;
    hwint = 6'h3F; exc_valid = 1'b0; exc_code = 5'd0; eret = 1'b0;
    m_sr = 0; m_cause = 0; m_epc = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);

    // Reset state with all lines high.
    tick();
    read("rst_sr", 5'd12, 32'h0);
    read("rst_cause", 5'd13, 32'h0);
    read("rst_epc", 5'd14, 32'h0);
    read("rst_prid", 5'd15, PRID_VAL);
    check("rst_intreq", 32'(intreq), 32'h0);
    reset = 1'b0;
    tick();
    read("cause_after_rst", 5'd13, 32'h0000_FC00);
    check("no_req_ie0", 32'(intreq), 32'h0);

    // Timer interrupt, not in a delay slot.
    hwint = 6'h0;
    mtc0(5'd12, 32'h0000_0401);
    hwint = 6'b000001; pc = 32'h0000_3008; bd = 1'b0;
    #1 check("irq_latency_n", 32'(intreq), 32'h0);
    tick();
    check("irq_n1", 32'(intreq), 32'h1);
    tick();
    read("irq_epc", 5'd14, 32'h0000_3008);
    read("irq_sr", 5'd12, 32'h0000_0403);
    check("irq_code", 32'(rdata[6:2]), 32'h0);
    sel = 5'd13; #1 check("irq_code", 32'(rdata[6:2]), 32'h0);
    check("irq_drop_n2", 32'(intreq), 32'h0);

    // eret with the line still high re-enters on the next cycle.
    eret = 1'b1;
    tick();
    eret = 1'b0;
    #1 check("eret_reassert", 32'(intreq), 32'h1);
    tick();
    // eret with the line low stays quiet.
    hwint = 6'h0; eret = 1'b1;
    tick();
    eret = 1'b0;
    read("eret_sr", 5'd12, 32'h0000_0401);
    check("eret_quiet", 32'(intreq), 32'h0);
    tick();

    // Delay-slot entry.
    hwint = 6'b000001; pc = 32'h0000_3010; bd = 1'b1;
    tick();
    check("bd_req", 32'(intreq), 32'h1);
    tick();
    read("bd_epc", 5'd14, 32'h0000_300C);
    sel = 5'd13; #1 check("bd_bit", 32'(rdata[31]), 32'h1);
    bd = 1'b0; hwint = 6'h0; eret = 1'b1;
    tick();
    eret = 1'b0;

    // Synchronous exception ignores IE.
    mtc0(5'd12, 32'h0);
    exc_valid = 1'b1; exc_code = 5'd10; pc = 32'h0000_4000;
    #1 check("exc_same_cycle", 32'(intreq), 32'h1);
    tick();
    exc_valid = 1'b0;
    sel = 5'd13; #1 check("exc_code", 32'(rdata[6:2]), 32'd10);
    eret = 1'b1;
    tick();
    eret = 1'b0;

    // Interrupt and exception together: interrupt wins.
    mtc0(5'd12, 32'h0000_0401);
    hwint = 6'b000001;
    tick();
    exc_valid = 1'b1; exc_code = 5'd10;
    tick();
    exc_valid = 1'b0;
    sel = 5'd13; #1 check("prio_code", 32'(rdata[6:2]), 32'h0);
    hwint = 6'h0; eret = 1'b1;
    tick();
    eret = 1'b0;

    // Software write paths.
    mtc0(5'd14, 32'h0000_3003);
    read("epc_align", 5'd14, 32'h0000_3000);
    mtc0(5'd13, 32'hFFFF_FFFF);
    read("cause_ro", 5'd13, m_read(5'd13));
    check("cause_ro_lo", 32'(rdata[9:7]), 32'h0);

    // mtc0 SR dropped when entry happens in the same cycle.
    hwint = 6'b000001;
    tick();
    sel = 5'd12; we = 1'b1; wdata = 32'h0;
    #1 check("wr_vs_entry_req", 32'(intreq), 32'h1);
    tick();
    we = 1'b0;
    read("wr_dropped_sr", 5'd12, 32'h0000_0403);
    hwint = 6'h0; eret = 1'b1;
    tick();
    eret = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 99) < 2);
      sel       = 5'($urandom_range(10, 16));
      we        = ($urandom_range(0, 9) < 3);
      wdata     = $urandom;
      pc        = $urandom;
      bd        = 1'($urandom);
      hwint     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
      exc_valid = ($urandom_range(0, 9) == 0);
      exc_code  = 5'($urandom);
      eret      = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
